irq_timer: RTL and testbench



---
 rtl/irq_timer.sv | 177 +++++++++++++++++
 tb/tb_irq_timer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
// Module   : irq_timer
// Purpose  : Memory-mapped countdown timer driving one CP0 HWInt line.
//            Registers: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (RO),
//            3 PRESCALE (only with TIMER_PRESCALE_EN defined, else reads 0).
//            One-shot mode holds irq until a CPU write to CTRL/PRESET;
//            auto-reload mode emits a one-cycle pulse every PRESET+2 cycles.
// Options  : `define TIMER_PRESCALE_EN to add the CNT-state prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module irq_timer #(
  parameter int PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;

  logic                  w_ctrl_wr;
  logic                  w_preset_wr;
  logic                  w_en;
  logic                  w_auto;
  logic                  w_tick;        // COUNT may step / expire this cycle
  logic                  w_expire;      // COUNT is 0 or 1: no wrap below zero
  logic [PRESCALE_W-1:0] w_prescale_rd; // value returned at addr 3

  assign w_ctrl_wr   = we && (addr == 2'd0);
  assign w_preset_wr = we && (addr == 2'd1);
  assign w_en        = ctrl_q[0];
  assign w_auto      = (ctrl_q[2:1] == 2'b01);
  assign w_expire    = (count_q <= 32'd1);

  // irq comes only from flops, so no path from din/we to the HWInt line
  assign irq = pending_q & ctrl_q[3];

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;

  // ">=" keeps the prescaler from running away if PRESCALE shrinks mid-count
  assign w_tick        = (psc_q >= prescale_q);
  assign w_prescale_rd = prescale_q;

  // Prescale register write and prescale counter advance (0..PRESCALE in CNT)
  always_comb begin
    prescale_d = prescale_q;
    psc_d      = '0;
    if (we && (addr == 2'd3)) begin
      prescale_d = din[PRESCALE_W-1:0];
    end
    if ((state_q == ST_CNT) && w_en && !w_tick) begin
      psc_d = psc_q + 1'b1;
    end
  end

  // Prescaler state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
      psc_q      <= '0;
    end else begin
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
    end
  end
`else
  assign w_tick        = 1'b1;
  assign w_prescale_rd = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_en) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_CNT;
      ST_CNT: begin
        if (!w_en) begin
          state_d = ST_IDLE;
        end else if (w_tick && w_expire) begin
          state_d = ST_INT;
        end
      end
      default: state_d = w_auto ? ST_LOAD : ST_IDLE;
    endcase
  end

  // Register updates: FSM effects first, then CPU writes override them
  always_comb begin
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    case (state_q)
      ST_LOAD: count_d = preset_q;
      ST_CNT: begin
        if (w_en && w_tick) begin
          if (w_expire) begin
            count_d   = 32'd0;
            pending_d = 1'b1;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
      end
      ST_INT: begin
        if (w_auto) begin
          pending_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
      default: ;
    endcase
    if (w_ctrl_wr) begin
      ctrl_d    = din[3:0];
      pending_d = 1'b0;
    end
    if (w_preset_wr) begin
      preset_d  = din;
      pending_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Read mux, combinational from addr
  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout = {28'd0, ctrl_q};
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = 32'(w_prescale_rd);
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_timer
// Purpose  : Self-checking bench for irq_timer: directed timing scenarios
//            plus randomized register traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_timer;

  localparam int PW = 8;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_checks;
  int n_fail;

  irq_timer #(.PRESCALE_W(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phases named after the timer's observable activity.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_FIRE = 3;

  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic [31:0] m_prescale;
  logic        m_pend;
  int          m_ph;
  int          m_psc;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return m_prescale;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [1:0] a,
                            input logic [31:0] d);
    logic [3:0]  nc;
    logic [31:0] np, ncnt, nps;
    logic        npend;
    int          nph, npsc;
    if (r) begin
      m_ctrl = 0; m_preset = 0; m_count = 0; m_prescale = 0;
      m_pend = 0; m_ph = PH_IDLE; m_psc = 0;
      return;
    end
    nc = m_ctrl; np = m_preset; ncnt = m_count; nps = m_prescale;
    npend = m_pend; nph = m_ph; npsc = 0;
    if (m_ph == PH_IDLE) begin
      if (m_ctrl[0]) nph = PH_LOAD;
    end else if (m_ph == PH_LOAD) begin
      ncnt = m_preset;
      nph  = PH_RUN;
    end else if (m_ph == PH_RUN) begin
      if (!m_ctrl[0]) begin
        nph = PH_IDLE;
      end else if (m_psc < int'(m_prescale)) begin
        npsc = m_psc + 1;
      end else if (m_count > 1) begin
        ncnt = m_count - 1;
      end else begin
        ncnt  = 0;
        npend = 1'b1;
        nph   = PH_FIRE;
      end
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin
        npend = 1'b0;
        nph   = PH_LOAD;
      end else begin
        nc[0] = 1'b0;
        nph   = PH_IDLE;
      end
    end
    if (w && a == 2'd0) begin nc = d[3:0]; npend = 1'b0; end
    if (w && a == 2'd1) begin np = d;      npend = 1'b0; end
`ifdef TIMER_PRESCALE_EN
    if (w && a == 2'd3) nps = 32'(d[PW-1:0]);
`endif
    m_ctrl = nc; m_preset = np; m_count = ncnt; m_prescale = nps;
    m_pend = npend; m_ph = nph; m_psc = npsc;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against model, clock edge, update model.
  task automatic tick(input logic r, input logic w, input logic [1:0] a,
                      input logic [31:0] d);
    reset = r; we = w; addr = a; din = d;
    #1;
    check("dout", dout, m_read(a));
    check("irq", {31'd0, irq}, {31'd0, m_pend & m_ctrl[3]});
    @(posedge clk);
    model_step(r, w, a, d);
    @(negedge clk);
    we = 1'b0;
    reset = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'd2, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; we = 1'b0; addr = 2'd0; din = 32'd0;
    model_step(1'b1, 1'b0, 2'd0, 32'd0);
    @(negedge clk);

    // Reset state
    tick(1'b1, 1'b0, 2'd0, 32'd0);
    tick(1'b1, 1'b0, 2'd0, 32'd0);
    for (int a = 0; a < 4; a++) begin
      tick(1'b0, 1'b0, 2'(a), 32'd0);
      check("rst_read", dout, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
    end

    // One-shot: PRESET=5, CTRL=1001
    tick(1'b0, 1'b1, 2'd1, 32'd5);
    tick(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      tick(1'b0, 1'b0, 2'd2, 32'd0);
      if (k >= 2) check("os_count", dout, 32'(7 - k));
      check("os_irq", {31'd0, irq}, {31'd0, k == 7});
    end
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    check("os_ctrl", dout, 32'h8);
    check("os_irq_hold", {31'd0, irq}, 32'd1);
    tick(1'b0, 1'b1, 2'd0, 32'h8);
    check("os_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload: PRESET=3, CTRL=1011
    tick(1'b0, 1'b1, 2'd1, 32'd3);
    tick(1'b0, 1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      tick(1'b0, 1'b0, 2'd2, 32'd0);
      check("ar_irq", {31'd0, irq}, {31'd0, (k >= 5) && ((k - 5) % 5 == 0)});
      if (k >= 7 && (k - 7) % 5 == 0) check("ar_reload", dout, 32'd3);
    end
    tick(1'b0, 1'b1, 2'd0, 32'h0);
    idle(4);

    // Masked expiry, then IM-only writes
    tick(1'b0, 1'b1, 2'd1, 32'd2);
    tick(1'b0, 1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0, 1'b0, 2'd2, 32'd0);
      check("mask_irq", {31'd0, irq}, 32'd0);
    end
    tick(1'b0, 1'b1, 2'd0, 32'h8);
    check("mask_clr", {31'd0, irq}, 32'd0);
    tick(1'b0, 1'b1, 2'd0, 32'h1);
    idle(6);
    tick(1'b0, 1'b1, 2'd0, 32'h8);
    idle(2);
    check("mask_im_wr", {31'd0, irq}, 32'd0);

    // Mid-count PRESET write does not disturb current count
    tick(1'b0, 1'b1, 2'd1, 32'd10);
    tick(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) tick(1'b0, 1'b0, 2'd2, 32'd0);
    check("mc_count6", dout, 32'd6);
    tick(1'b0, 1'b1, 2'd1, 32'd2);
    check("mc_preset", dout, 32'd2);
    for (int k = 8; k <= 13; k++) begin
      tick(1'b0, 1'b0, 2'd2, 32'd0);
      check("mc_irq", {31'd0, irq}, {31'd0, k >= 12});
    end
    tick(1'b0, 1'b1, 2'd0, 32'h0);

    // EN cleared mid-count: COUNT holds, no irq
    tick(1'b0, 1'b1, 2'd1, 32'd10);
    tick(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) tick(1'b0, 1'b0, 2'd2, 32'd0);
    check("en_count4", dout, 32'd4);
    tick(1'b0, 1'b1, 2'd0, 32'h8);
    for (int k = 10; k <= 15; k++) begin
      tick(1'b0, 1'b0, 2'd2, 32'd0);
      check("en_hold", dout, 32'd3);
      check("en_irq", {31'd0, irq}, 32'd0);
    end

    // Reset during CNT
    tick(1'b0, 1'b1, 2'd0, 32'h9);
    idle(5);
    tick(1'b1, 1'b0, 2'd2, 32'd0);
    check("rc_count", dout, 32'd0);
    check("rc_irq", {31'd0, irq}, 32'd0);
    tick(1'b0, 1'b0, 2'd0, 32'd0);
    check("rc_ctrl", dout, 32'd0);

`ifdef TIMER_PRESCALE_EN
    // Prescaler: PRESCALE=2, PRESET=3 -> irq 11 cycles after EN write
    tick(1'b0, 1'b1, 2'd3, 32'd2);
    check("ps_rd", dout, 32'd2);
    tick(1'b0, 1'b1, 2'd1, 32'd3);
    tick(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 1'b0, 2'd2, 32'd0);
      check("ps_irq", {31'd0, irq}, {31'd0, k >= 11});
    end
    tick(1'b0, 1'b1, 2'd0, 32'h0);
    tick(1'b0, 1'b1, 2'd3, 32'd0);
`else
    // Addr 3 writes ignored in the default build
    tick(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF);
    check("ps_none", dout, 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      int op;
      logic r;
      r  = ($urandom_range(0, 299) == 0);
      op = $urandom_range(0, 11);
      if (op < 2)
        tick(r, 1'b1, 2'd0, $urandom | (($urandom_range(0, 2) != 0) ? 32'h1 : 32'h0));
      else if (op == 2)
        tick(r, 1'b1, 2'd1, 32'($urandom_range(0, 6)));
      else if (op == 3)
        tick(r, 1'b1, 2'd2, $urandom);
      else if (op == 4)
        tick(r, 1'b1, 2'd3, 32'($urandom_range(0, 3)));
      else
        tick(r, 1'b0, 2'($urandom_range(0, 3)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
